// File: rtl/joy_db9_scanner_pkg.sv
// Shared constants and FSM state type for the DB9 joystick scanner.
package joy_pkg;
  localparam int JOY_UP    = 0;
  localparam int JOY_DOWN  = 1;
  localparam int JOY_LEFT  = 2;
  localparam int JOY_RIGHT = 3;
  localparam int JOY_FIRE1 = 4;
  localparam int JOY_FIRE2 = 5;
  localparam int JOY_FIRE3 = 6;
  localparam int JOY_START = 7;

  localparam int JOY_FRAME_W = 16;
  localparam int JOY_W       = JOY_FRAME_W / 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SAMPLE,
    SHIFT,
    DONE
  } joy_state_e;
endpackage

// File: rtl/joy_db9_scanner_if.sv
// Chain pins, external-scanner pins and core-facing joystick words.
interface joy_db9_scanner_if;
  import joy_pkg::*;

  logic             joy_clk;
  logic             joy_load_n;
  logic             joy_data;
  logic             xjoy_clk;
  logic             xjoy_load_n;
  logic             xjoy_data;
  logic [JOY_W-1:0] joy1;
  logic [JOY_W-1:0] joy2;
  logic             valid;

  modport master (
    output joy_clk, joy_load_n, xjoy_data, joy1, joy2, valid,
    input  joy_data, xjoy_clk, xjoy_load_n
  );

  modport slave (
    input  joy_clk, joy_load_n, xjoy_data, joy1, joy2, valid,
    output joy_data, xjoy_clk, xjoy_load_n
  );
endinterface

// File: rtl/joy_db9_scanner_tick.sv
// Free-running divider: one-cycle tick every DIV clocks, cleared by reset.
module joy_tick_gen #(
  parameter int DIV = 25
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int            W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  TOP = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = (cnt_q == TOP) ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == TOP);
endmodule

// File: rtl/joy_db9_scanner.sv
// Scans the joystick shift-register chain, debounces two consecutive frames
// and publishes active-high joystick words; optional pass-through to an external scanner.
module joy_db9_scanner import joy_pkg::*; #(
  parameter int CLKDIV   = 25,
  parameter int SCAN_DIV = 50000,
  parameter int NBITS    = JOY_FRAME_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 passthru,
  joy_db9_scanner_if.master    bus
);
  localparam int              BW   = $clog2(NBITS);
  localparam logic [BW-1:0]   LAST = BW'(NBITS - 1);

  logic tick, scan_wrap;

  joy_tick_gen #(.DIV(CLKDIV))   u_tick (.clk(clk), .reset(reset), .tick(tick));
  joy_tick_gen #(.DIV(SCAN_DIV)) u_scan (.clk(clk), .reset(reset), .tick(scan_wrap));

  joy_state_e       state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [NBITS-1:0] frame_q, frame_d, prev_q, prev_d;
  logic [JOY_W-1:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic             valid_q, valid_d;
  logic             start_req_q, start_req_d;
  logic             jclk_q, jclk_d, jload_n_q, jload_n_d;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    frame_d     = frame_q;
    prev_d      = prev_q;
    joy1_d      = joy1_q;
    joy2_d      = joy2_q;
    valid_d     = 1'b0;
    start_req_d = start_req_q;
    if (passthru) begin
      state_d     = IDLE;
      start_req_d = 1'b0;
    end else begin
      case (state_q)
        // A wrap coinciding with a tick is consumed at once; otherwise it waits here.
        IDLE: begin
          if (tick && (start_req_q || scan_wrap)) begin
            start_req_d = 1'b0;
            state_d     = LOAD;
          end else if (scan_wrap) begin
            start_req_d = 1'b1;
          end
        end
        LOAD: if (tick) begin
          bitcnt_d = '0;
          state_d  = SAMPLE;
        end
        SAMPLE: if (tick) begin
          frame_d[LAST - bitcnt_q] = bus.joy_data;
          state_d                  = SHIFT;
        end
        SHIFT: if (tick) begin
          if (bitcnt_q == LAST) state_d = DONE;
          else begin
            bitcnt_d = bitcnt_q + 1'b1;
            state_d  = SAMPLE;
          end
        end
        DONE: begin
          if (frame_q == prev_q) begin
            joy1_d  = ~frame_q[NBITS-1 -: JOY_W];
            joy2_d  = ~frame_q[JOY_W-1:0];
            valid_d = 1'b1;
          end
          prev_d  = frame_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Chain pins are registered from the next state so they line up with state_q.
    jclk_d    = (state_d == SHIFT);
    jload_n_d = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      frame_q     <= '1;
      prev_q      <= '1;
      joy1_q      <= '0;
      joy2_q      <= '0;
      valid_q     <= 1'b0;
      start_req_q <= 1'b0;
      jclk_q      <= 1'b0;
      jload_n_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      frame_q     <= frame_d;
      prev_q      <= prev_d;
      joy1_q      <= joy1_d;
      joy2_q      <= joy2_d;
      valid_q     <= valid_d;
      start_req_q <= start_req_d;
      jclk_q      <= jclk_d;
      jload_n_q   <= jload_n_d;
    end
  end

  assign bus.joy_clk    = !reset && (passthru ? bus.xjoy_clk : jclk_q);
  assign bus.joy_load_n = reset || (passthru ? bus.xjoy_load_n : jload_n_q);
  assign bus.xjoy_data  = reset || !passthru || bus.joy_data;
  assign bus.joy1       = joy1_q;
  assign bus.joy2       = joy2_q;
  assign bus.valid      = valid_q;
endmodule

// File: tb/tb_joy_db9_scanner.sv
// Directed bench: chain model feeds frame patterns, table of expected debounced outputs.
module tb_joy_db9_scanner;
  logic clk = 1'b0;
  logic reset, passthru;

  joy_db9_scanner_if bus();

  joy_db9_scanner #(.CLKDIV(2), .SCAN_DIV(100)) dut (
    .clk(clk), .reset(reset), .passthru(passthru), .bus(bus)
  );

  always #5 clk = ~clk;

  // Two-chip '165 chain model: parallel load while load_n low, shift on joy_clk rise.
  logic [15:0] pat = 16'hFFFF;
  logic [15:0] sr  = 16'hFFFF;
  logic        jcp = 1'b0;
  logic        pt_drive = 1'b0, pt_data = 1'b1;

  always @(posedge clk) begin
    if (!bus.joy_load_n)            sr <= pat;
    else if (bus.joy_clk && !jcp)   sr <= {sr[14:0], 1'b1};
    jcp <= bus.joy_clk;
  end

  assign bus.joy_data = pt_drive ? pt_data : sr[15];

  int cyc = 0, vcount = 0, rcount = 0, last_vcyc = 0;
  logic jc_mon = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid) begin
      vcount    <= vcount + 1;
      last_vcyc <= cyc;
    end
    if (bus.joy_clk && !jc_mon) rcount <= rcount + 1;
    jc_mon <= bus.joy_clk;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_load(output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
    end while (bus.joy_load_n && n < 300);
    chk("load_seen", 32'(bus.joy_load_n), 32'd0);
  endtask

  typedef struct {
    logic [15:0] pat;
    int          exp_v;
    logic [7:0]  exp_j1;
    logic [7:0]  exp_j2;
  } vec_t;

  vec_t tbl[9];

  task automatic do_frame(input vec_t v, input int i);
    int vb, rb, l, n;
    pat = v.pat;
    vb  = vcount;
    rb  = rcount;
    wait_load(n);
    l = cyc;
    repeat (70) @(posedge clk);
    @(negedge clk);
    chk($sformatf("row%0d_valid_cnt", i), 32'(vcount - vb), 32'(v.exp_v));
    chk($sformatf("row%0d_jclk_edges", i), 32'(rcount - rb), 32'd16);
    chk($sformatf("row%0d_joy1", i), 32'(bus.joy1), 32'(v.exp_j1));
    chk($sformatf("row%0d_joy2", i), 32'(bus.joy2), 32'(v.exp_j2));
    if (v.exp_v != 0) chk($sformatf("row%0d_valid_lat", i), 32'(last_vcyc - l), 32'd67);
  endtask

  initial begin
    int n, vb;
    tbl[0] = '{16'h7FFE, 0, 8'h00, 8'h00};
    tbl[1] = '{16'h7FFE, 1, 8'h80, 8'h01};
    tbl[2] = '{16'hFFFF, 0, 8'h80, 8'h01};
    tbl[3] = '{16'h00FF, 0, 8'h80, 8'h01};
    tbl[4] = '{16'hFFFF, 0, 8'h80, 8'h01};
    tbl[5] = '{16'hFFFF, 1, 8'h00, 8'h00};
    tbl[6] = '{16'hFFFF, 1, 8'h00, 8'h00};
    tbl[7] = '{16'h5AA5, 0, 8'h00, 8'h00};
    tbl[8] = '{16'h5AA5, 1, 8'hA5, 8'h5A};

    // Reset with pass-through requested: reset values must still win.
    reset = 1'b1; passthru = 1'b1;
    bus.xjoy_clk = 1'b1; bus.xjoy_load_n = 1'b0;
    pt_drive = 1'b1; pt_data = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_joy_clk",   32'(bus.joy_clk),    32'd0);
    chk("rst_load_n",    32'(bus.joy_load_n), 32'd1);
    chk("rst_xjoy_data", 32'(bus.xjoy_data),  32'd1);
    passthru = 1'b0; pt_drive = 1'b0;
    bus.xjoy_clk = 1'b0; bus.xjoy_load_n = 1'b1;
    #1;
    chk("rst_joy1",  32'(bus.joy1),  32'd0);
    chk("rst_joy2",  32'(bus.joy2),  32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    wait_load(n);
    chk("first_load_cycle", 32'(n), 32'd100);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 9; i++) do_frame(tbl[i], i);

    // Internal scan: xjoy_data is tied high regardless of joy_data.
    pt_drive = 1'b1; pt_data = 1'b0; #1;
    chk("int_xjoy_data", 32'(bus.xjoy_data), 32'd1);

    // Pass-through across more than one scan period.
    passthru = 1'b1; vb = vcount;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      {bus.xjoy_clk, bus.xjoy_load_n, pt_data} = 3'($urandom);
      #1;
      chk("pt_joy_clk",   32'(bus.joy_clk),    32'(bus.xjoy_clk));
      chk("pt_load_n",    32'(bus.joy_load_n), 32'(bus.xjoy_load_n));
      chk("pt_xjoy_data", 32'(bus.xjoy_data),  32'(pt_data));
    end
    @(negedge clk);
    chk("pt_valid_cnt", 32'(vcount - vb), 32'd0);
    chk("pt_joy1_hold", 32'(bus.joy1), 32'hA5);
    chk("pt_joy2_hold", 32'(bus.joy2), 32'h5A);
    bus.xjoy_clk = 1'b0; bus.xjoy_load_n = 1'b1;
    passthru = 1'b0; pt_drive = 1'b0;

    // Abort at bit 7 with different data; the following 5AA5 frame must still match.
    pat = 16'h1234; vb = vcount;
    wait_load(n);
    repeat (32) @(posedge clk);
    #1 passthru = 1'b1;
    repeat (3) @(posedge clk);
    #1 passthru = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("abort_valid_cnt", 32'(vcount - vb), 32'd0);
    chk("abort_joy1", 32'(bus.joy1), 32'hA5);
    chk("abort_joy2", 32'(bus.joy2), 32'h5A);
    do_frame('{16'h5AA5, 1, 8'hA5, 8'h5A}, 9);

    // Reset during SHIFT of bit 10.
    pat = 16'h0000;
    wait_load(n);
    repeat (44) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_joy1",    32'(bus.joy1),       32'd0);
    chk("mrst_joy2",    32'(bus.joy2),       32'd0);
    chk("mrst_valid",   32'(bus.valid),      32'd0);
    chk("mrst_load_n",  32'(bus.joy_load_n), 32'd1);
    chk("mrst_joy_clk", 32'(bus.joy_clk),    32'd0);
    @(posedge clk); #1 reset = 1'b0;
    wait_load(n);
    chk("mrst_next_load_cycle", 32'(n), 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
